// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter.
package ram_arb_pkg;
  typedef enum logic {CLEAR, RUN} state_t;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin chooser; `last` is the index of the most recent winner.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    // On contention the side that did not win last time takes the port
    if (&req) gnt = (last == 1'(REQ_B)) ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin sharer of one synchronous RAM port between requesters A and B.
// Define RAM_ARB_CLEAR_EN to sweep CLEAR_VALUE through the RAM after reset.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int             SIZE        = 8,
  parameter int             DEPTH       = 64,
  parameter logic [SIZE-1:0] CLEAR_VALUE = '0,
  localparam int            AW          = aw_of(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [SIZE-1:0] a_wdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [SIZE-1:0] b_wdata,
  output logic            a_gnt,
  output logic            b_gnt,
  output logic            a_rvalid,
  output logic            b_rvalid,
  output logic [SIZE-1:0] rdata,
  output logic [AW-1:0]   ram_address,
  output logic [SIZE-1:0] ram_write_data,
  output logic            ram_write_en,
  input  logic [SIZE-1:0] ram_read_data,
  output logic            busy
);
  logic          run, sweep, last, rv_a, rv_b;
  logic [1:0]    req, gnt;
  logic [AW-1:0] sweep_addr, addr_q;

`ifdef RAM_ARB_CLEAR_EN
  state_t        state;
  logic [AW-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH - 1)) state <= RUN;
    end
  end

  assign run        = rst_n && (state == RUN);
  assign sweep      = rst_n && (state == CLEAR);
  assign sweep_addr = clr_cnt;
  assign busy       = !rst_n || (state == CLEAR);
`else
  assign run        = rst_n;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
  assign busy       = 1'b0;
`endif

  always_comb begin
    req        = '0;
    req[REQ_A] = a_req && run;
    req[REQ_B] = b_req && run;
  end

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .gnt  (gnt)
  );

  assign a_gnt = gnt[REQ_A];
  assign b_gnt = gnt[REQ_B];

  // Idle cycles keep the previous address so the RAM address bus stays quiet
  always_comb begin
    ram_address    = addr_q;
    ram_write_data = CLEAR_VALUE;
    ram_write_en   = 1'b0;
    if (sweep) begin
      ram_address  = sweep_addr;
      ram_write_en = 1'b1;
    end else if (gnt[REQ_A]) begin
      ram_address    = a_addr;
      ram_write_data = a_wdata;
      ram_write_en   = a_we;
    end else if (gnt[REQ_B]) begin
      ram_address    = b_addr;
      ram_write_data = b_wdata;
      ram_write_en   = b_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last   <= 1'(REQ_B);
      rv_a   <= 1'b0;
      rv_b   <= 1'b0;
      addr_q <= '0;
    end else begin
      rv_a   <= gnt[REQ_A] && !a_we;
      rv_b   <= gnt[REQ_B] && !b_we;
      addr_q <= ram_address;
      if (|gnt) last <= gnt[REQ_B];
    end
  end

  // Gating with rst_n drops a read result that lands while reset is held
  assign a_rvalid = rv_a && rst_n;
  assign b_rvalid = rv_b && rst_n;
  assign rdata    = ram_read_data;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural read-first RAM alongside.
module tb_ram_arbiter;
  localparam int SIZE = 8;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam logic [7:0] CLR = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [SIZE-1:0] a_wdata, b_wdata;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
  logic [SIZE-1:0] rdata, ram_write_data, ram_read_data;
  logic [AW-1:0] ram_address;
  logic ram_write_en;
  logic [SIZE-1:0] mem [DEPTH];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH), .CLEAR_VALUE(CLR)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_write_en(ram_write_en), .ram_read_data(ram_read_data), .busy(busy)
  );

  // Read-first single-port RAM with a one-cycle registered read
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef RAM_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  // Read-data check for locations that only hold known data after a sweep
  task automatic chk_swept(input string tag, input logic [7:0] exp_no_sweep, input bit known);
    if (CLR_EN) chk(tag, {24'h0, rdata}, {24'h0, CLR});
    else if (known) chk(tag, {24'h0, rdata}, {24'h0, exp_no_sweep});
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Release reset with both requesters reading; returns at the first RUN cycle
  task automatic release_run(input logic [AW-1:0] aa, input logic [AW-1:0] ba);
    int n, g;
    step;
    a_req = 1'b1; a_we = 1'b0; a_addr = aa;
    b_req = 1'b1; b_we = 1'b0; b_addr = ba;
    rst_n = 1'b1;
    n = 0; g = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!busy) break;
      n++;
      if (a_gnt || b_gnt || (ram_write_en && ram_write_data !== CLR)) g++;
      @(negedge clk);
    end
    chk("sweep_len", n, CLR_EN ? 32'd64 : 32'd0);
    chk("sweep_no_gnt", g, 0);
    chk("run_busy", {31'h0, busy}, 0);
    chk("run_first_a_gnt", {31'h0, a_gnt}, 1);
    chk("run_first_b_gnt", {31'h0, b_gnt}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = '0; a_wdata = '0;
    b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    step; step; #1;
    chk("rst_a_gnt", {31'h0, a_gnt}, 0);
    chk("rst_b_gnt", {31'h0, b_gnt}, 0);
    chk("rst_a_rvalid", {31'h0, a_rvalid}, 0);
    chk("rst_b_rvalid", {31'h0, b_rvalid}, 0);
    chk("rst_we", {31'h0, ram_write_en}, 0);
    chk("rst_busy", {31'h0, busy}, {31'h0, CLR_EN});

    // Contention: A@0 granted first, B@31 waits
    release_run(6'd0, 6'd31);
    step; a_addr = 6'd63; #1;
    chk("c1_a_rvalid", {31'h0, a_rvalid}, 1);
    chk("c1_b_rvalid", {31'h0, b_rvalid}, 0);
    chk("c1_b_gnt", {31'h0, b_gnt}, 1);
    chk("c1_a_gnt", {31'h0, a_gnt}, 0);
    chk_swept("c1_rdata", 8'h00, 1'b0);
    step; b_req = 1'b0; #1;
    chk("c2_b_rvalid", {31'h0, b_rvalid}, 1);
    chk("c2_a_rvalid", {31'h0, a_rvalid}, 0);
    chk("c2_a_gnt", {31'h0, a_gnt}, 1);
    chk_swept("c2_rdata", 8'h00, 1'b0);
    step; a_req = 1'b0; #1;
    chk("c3_a_rvalid", {31'h0, a_rvalid}, 1);
    chk("c3_idle_we", {31'h0, ram_write_en}, 0);
    chk("c3_idle_gnt", {30'h0, a_gnt, b_gnt}, 0);
    chk_swept("c3_rdata", 8'h00, 1'b0);

    // Single requester write then read of address 5
    step; a_req = 1'b1; a_we = 1'b1; a_addr = 6'd5; a_wdata = 8'h3C; #1;
    chk("w_a_gnt", {31'h0, a_gnt}, 1);
    chk("w_we", {31'h0, ram_write_en}, 1);
    chk("w_addr", {26'h0, ram_address}, 5);
    chk("w_data", {24'h0, ram_write_data}, 8'h3C);
    step; a_we = 1'b0; #1;
    chk("r_a_gnt", {31'h0, a_gnt}, 1);
    chk("r_we", {31'h0, ram_write_en}, 0);
    chk("w_no_rvalid", {31'h0, a_rvalid}, 0);
    step; a_req = 1'b0; #1;
    chk("r_a_rvalid", {31'h0, a_rvalid}, 1);
    chk("r_b_rvalid", {31'h0, b_rvalid}, 0);
    chk("r_rdata", {24'h0, rdata}, 8'h3C);

    // B alone writes 10..12, then contention: A must win since B was last
    for (int i = 0; i < 3; i++) begin
      step; b_req = 1'b1; b_we = 1'b1; b_addr = AW'(10 + i); b_wdata = 8'(8'h50 + i); #1;
      chk("b_alone_gnt", {31'h0, b_gnt}, 1);
      chk("b_alone_we", {31'h0, ram_write_en}, 1);
    end
    step; a_req = 1'b1; a_we = 1'b0; a_addr = 6'd10; b_we = 1'b0; b_addr = 6'd12; #1;
    chk("ptr_hold_a", {31'h0, a_gnt}, 1);
    chk("ptr_hold_b", {31'h0, b_gnt}, 0);
    step; a_addr = 6'd11; #1;
    chk("p1_a_rvalid", {31'h0, a_rvalid}, 1);
    chk("p1_rdata", {24'h0, rdata}, 8'h50);
    chk("p1_b_gnt", {31'h0, b_gnt}, 1);
    step; b_addr = 6'd10; #1;
    chk("p2_b_rvalid", {31'h0, b_rvalid}, 1);
    chk("p2_rdata", {24'h0, rdata}, 8'h52);
    chk("p2_a_gnt", {31'h0, a_gnt}, 1);
    step; a_req = 1'b0; #1;
    chk("p3_a_rvalid", {31'h0, a_rvalid}, 1);
    chk("p3_rdata", {24'h0, rdata}, 8'h51);
    chk("p3_b_gnt", {31'h0, b_gnt}, 1);
    step; b_req = 1'b0; #1;
    chk("p4_b_rvalid", {31'h0, b_rvalid}, 1);
    chk("p4_rdata", {24'h0, rdata}, 8'h50);
    chk("idle_addr_hold", {26'h0, ram_address}, 10);

    // Reset in the cycle after A's read grant suppresses the read result
    step; a_req = 1'b1; a_we = 1'b0; a_addr = 6'd5; #1;
    chk("mid_a_gnt", {31'h0, a_gnt}, 1);
    step; a_req = 1'b0; rst_n = 1'b0; #1;
    chk("mid_rst_a_rvalid", {31'h0, a_rvalid}, 0);
    chk("mid_rst_busy", {31'h0, busy}, {31'h0, CLR_EN});
    step; #1;
    chk("mid_rst_a_rvalid2", {31'h0, a_rvalid}, 0);

    // Re-release: A was last before reset, so A wins only if the pointer reset
    release_run(6'd5, 6'd12);
    step; a_req = 1'b0; #1;
    chk("rr_a_rvalid", {31'h0, a_rvalid}, 1);
    chk("rr_b_gnt", {31'h0, b_gnt}, 1);
    chk_swept("rr_a_rdata", 8'h3C, 1'b1);
    step; b_req = 1'b0; #1;
    chk("rr_b_rvalid", {31'h0, b_rvalid}, 1);
    chk_swept("rr_b_rdata", 8'h52, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
